// File: rtl/sram_tp_be_clr.sv
// Single-clock true dual-port RAM with byte enables, per-port read-during-write
// mode, optional output register and a post-reset zero-fill sweep.
module sram_tp_be_clr #(
  parameter int unsigned g_D    = 512,
  parameter int unsigned g_W    = 32,
  parameter int unsigned g_BW   = 8,
  parameter int unsigned g_MODE = 0,
  parameter int unsigned g_OREG = 0,
  parameter int unsigned g_CLR  = 1,
  localparam int unsigned AW    = (g_D > 1) ? $clog2(g_D) : 1,
  localparam int unsigned NB    = g_W / g_BW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  input  logic          ena,
  input  logic [NB-1:0] wea,
  input  logic [AW-1:0] addra,
  input  logic [g_W-1:0] dina,
  output logic [g_W-1:0] douta,
  output logic          valida,
  input  logic          enb,
  input  logic [NB-1:0] web,
  input  logic [AW-1:0] addrb,
  input  logic [g_W-1:0] dinb,
  output logic [g_W-1:0] doutb,
  output logic          validb,
  output logic          coll
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  logic [g_W-1:0] mem [g_D];

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          ready_q, ready_d;

  logic          run_c, acc_a_c, acc_b_c, wr_a_c, wr_b_c, coll_c;
  logic [g_W-1:0] old_a_c, old_b_c, new_a_c, new_b_c;
  logic          ret_a_v_c, ret_b_v_c;
  logic [g_W-1:0] ret_a_d_c, ret_b_d_c;

  logic [g_W-1:0] douta1_q, douta1_d, doutb1_q, doutb1_d;
  logic          valida1_q, valida1_d, validb1_q, validb1_d, coll1_q, coll1_d;

  // Clear/run state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (g_CLR != 0) ? ST_CLEAR : ST_RUN;
      clr_addr_q <= '0;
      ready_q    <= (g_CLR == 0);
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
    end
  end

  // Sweep every address once, then hand the array to the ports
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(g_D - 1)) begin
          state_d    = ST_RUN;
          clr_addr_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Access decode, collision detect and the final stored word per port
  always_comb begin
    run_c   = (state_q == ST_RUN);
    acc_a_c = run_c & ena;
    acc_b_c = run_c & enb;
    wr_a_c  = acc_a_c & (|wea);
    wr_b_c  = acc_b_c & (|web);
    coll_c  = acc_a_c & acc_b_c & (addra == addrb) & (wr_a_c | wr_b_c);
    old_a_c = mem[addra];
    old_b_c = mem[addrb];
    new_a_c = old_a_c;
    new_b_c = old_b_c;
    // On collision both ports compute the same word; port A wins shared lanes
    for (int unsigned i = 0; i < NB; i++) begin
      if (coll_c && web[i]) new_a_c[i*g_BW +: g_BW] = dinb[i*g_BW +: g_BW];
      if (wea[i])           new_a_c[i*g_BW +: g_BW] = dina[i*g_BW +: g_BW];
      if (web[i])           new_b_c[i*g_BW +: g_BW] = dinb[i*g_BW +: g_BW];
      if (coll_c && wea[i]) new_b_c[i*g_BW +: g_BW] = dina[i*g_BW +: g_BW];
    end
    ret_a_v_c = acc_a_c & (~wr_a_c | (g_MODE != 2));
    ret_b_v_c = acc_b_c & (~wr_b_c | (g_MODE != 2));
    ret_a_d_c = (wr_a_c && (g_MODE == 0)) ? new_a_c : old_a_c;
    ret_b_d_c = (wr_b_c && (g_MODE == 0)) ? new_b_c : old_b_c;
  end

  // Memory array: not reset, zero-filled by the sweep
  always_ff @(posedge clk) begin
    if (!run_c) begin
      mem[clr_addr_q] <= '0;
    end else begin
      if (wr_b_c) mem[addrb] <= new_b_c;
      if (wr_a_c) mem[addra] <= new_a_c;
    end
  end

  always_comb begin
    douta1_d  = ret_a_v_c ? ret_a_d_c : douta1_q;
    doutb1_d  = ret_b_v_c ? ret_b_d_c : doutb1_q;
    valida1_d = ret_a_v_c;
    validb1_d = ret_b_v_c;
    coll1_d   = coll_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta1_q  <= '0;
      doutb1_q  <= '0;
      valida1_q <= 1'b0;
      validb1_q <= 1'b0;
      coll1_q   <= 1'b0;
    end else begin
      douta1_q  <= douta1_d;
      doutb1_q  <= doutb1_d;
      valida1_q <= valida1_d;
      validb1_q <= validb1_d;
      coll1_q   <= coll1_d;
    end
  end

  if (g_OREG != 0) begin : g_oreg
    logic [g_W-1:0] douta2_q, douta2_d, doutb2_q, doutb2_d;
    logic          valida2_q, validb2_q, coll2_q;

    always_comb begin
      douta2_d = valida1_q ? douta1_q : douta2_q;
      doutb2_d = validb1_q ? doutb1_q : doutb2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        douta2_q  <= '0;
        doutb2_q  <= '0;
        valida2_q <= 1'b0;
        validb2_q <= 1'b0;
        coll2_q   <= 1'b0;
      end else begin
        douta2_q  <= douta2_d;
        doutb2_q  <= doutb2_d;
        valida2_q <= valida1_q;
        validb2_q <= validb1_q;
        coll2_q   <= coll1_q;
      end
    end

    assign douta  = douta2_q;
    assign doutb  = doutb2_q;
    assign valida = valida2_q;
    assign validb = validb2_q;
    assign coll   = coll2_q;
  end else begin : g_noreg
    assign douta  = douta1_q;
    assign doutb  = doutb1_q;
    assign valida = valida1_q;
    assign validb = validb1_q;
    assign coll   = coll1_q;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_sram_tp_be_clr.sv
// Bench for sram_tp_be_clr: three instances (write-first, read-first with output
// register, no-change) share stimulus and are checked against an array model.
module tb_sram_tp_be_clr;

  localparam int unsigned D    = 16;
  localparam int unsigned W    = 32;
  localparam int unsigned NB   = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned NDUT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [W-1:0]  dina, dinb;

  logic [W-1:0]  dout_a [NDUT];
  logic [W-1:0]  dout_b [NDUT];
  logic          va [NDUT];
  logic          vb [NDUT];
  logic          co [NDUT];
  logic          rdy [NDUT];

  int n_err = 0;
  int n_chk = 0;

  // Reference model state
  logic [W-1:0] mem_m [D];
  int           clr_cnt;
  logic         pa_v [NDUT];
  logic         pb_v [NDUT];
  logic         pc   [NDUT];
  logic [W-1:0] pa_d [NDUT];
  logic [W-1:0] pb_d [NDUT];
  logic [W-1:0] ha   [NDUT];
  logic [W-1:0] hb   [NDUT];

  always #5 clk = ~clk;

  sram_tp_be_clr #(.g_D(D), .g_W(W), .g_BW(8), .g_MODE(0), .g_OREG(0), .g_CLR(1)) u0 (
    .clk(clk), .rst(rst), .ready(rdy[0]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_a[0]), .valida(va[0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_b[0]), .validb(vb[0]),
    .coll(co[0]));

  sram_tp_be_clr #(.g_D(D), .g_W(W), .g_BW(8), .g_MODE(1), .g_OREG(1), .g_CLR(1)) u1 (
    .clk(clk), .rst(rst), .ready(rdy[1]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_a[1]), .valida(va[1]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_b[1]), .validb(vb[1]),
    .coll(co[1]));

  sram_tp_be_clr #(.g_D(D), .g_W(W), .g_BW(8), .g_MODE(2), .g_OREG(0), .g_CLR(1)) u2 (
    .clk(clk), .rst(rst), .ready(rdy[2]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_a[2]), .valida(va[2]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_b[2]), .validb(vb[2]),
    .coll(co[2]));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] byte_merge(input logic [W-1:0] old_w,
                                              input logic [W-1:0] new_w,
                                              input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    clr_cnt = 0;
    for (int k = 0; k < NDUT; k++) begin
      pa_v[k] = 1'b0; pb_v[k] = 1'b0; pc[k] = 1'b0;
      pa_d[k] = '0;   pb_d[k] = '0;
      ha[k]   = '0;   hb[k]   = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s_u%0d_douta", tag, k), dout_a[k], '0);
      chk($sformatf("%s_u%0d_doutb", tag, k), dout_b[k], '0);
      chk($sformatf("%s_u%0d_valid", tag, k), W'({va[k], vb[k]}), '0);
      chk($sformatf("%s_u%0d_coll", tag, k), W'(co[k]), '0);
      chk($sformatf("%s_u%0d_ready", tag, k), W'(rdy[k]), '0);
    end
  endtask

  // One clock: predict from current inputs, advance, compare every instance
  task automatic step();
    logic         live, aa, ab, wa, wb, c;
    logic [W-1:0] olda, oldb;
    logic [W-1:0] mem_next [D];
    live = (clr_cnt >= D);
    aa   = live && ena;
    ab   = live && enb;
    wa   = aa && (wea != '0);
    wb   = ab && (web != '0);
    c    = aa && ab && (addra == addrb) && (wa || wb);
    olda = mem_m[addra];
    oldb = mem_m[addrb];
    mem_next = mem_m;
    if (wb) mem_next[addrb] = byte_merge(mem_next[addrb], dinb, web);
    if (wa) mem_next[addra] = byte_merge(mem_next[addra], dina, wea);

    @(posedge clk);
    #1;

    if (live) mem_m = mem_next;
    if (clr_cnt < D) begin
      clr_cnt++;
      if (clr_cnt == D)
        for (int i = 0; i < D; i++) mem_m[i] = '0;
    end

    for (int k = 0; k < NDUT; k++) begin
      logic         na_v, nb_v, ov_a, ov_b, oc;
      logic [W-1:0] na_d, nb_d, od_a, od_b;
      na_v = aa && (!wa || k != 2);
      nb_v = ab && (!wb || k != 2);
      na_d = (wa && k == 0) ? mem_next[addra] : olda;
      nb_d = (wb && k == 0) ? mem_next[addrb] : oldb;
      if (k == 1) begin
        ov_a = pa_v[k]; od_a = pa_d[k];
        ov_b = pb_v[k]; od_b = pb_d[k];
        oc   = pc[k];
        pa_v[k] = na_v; pa_d[k] = na_d;
        pb_v[k] = nb_v; pb_d[k] = nb_d;
        pc[k]   = c;
      end else begin
        ov_a = na_v; od_a = na_d;
        ov_b = nb_v; od_b = nb_d;
        oc   = c;
      end
      if (ov_a) ha[k] = od_a;
      if (ov_b) hb[k] = od_b;
      chk($sformatf("u%0d_douta", k), dout_a[k], ha[k]);
      chk($sformatf("u%0d_valida", k), W'(va[k]), W'(ov_a));
      chk($sformatf("u%0d_doutb", k), dout_b[k], hb[k]);
      chk($sformatf("u%0d_validb", k), W'(vb[k]), W'(ov_b));
      chk($sformatf("u%0d_coll", k), W'(co[k]), W'(oc));
      chk($sformatf("u%0d_ready", k), W'(rdy[k]), W'(clr_cnt >= D));
    end
  endtask

  task automatic drive(input logic a_en, input logic [NB-1:0] a_we, input logic [AW-1:0] a_ad,
                       input logic [W-1:0] a_d, input logic b_en, input logic [NB-1:0] b_we,
                       input logic [AW-1:0] b_ad, input logic [W-1:0] b_d);
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
    enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
    step();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rand_inputs();
    ena   = 1'($urandom_range(0, 1));
    enb   = 1'($urandom_range(0, 1));
    wea   = ($urandom_range(0, 1) != 0) ? NB'($urandom_range(0, 15)) : '0;
    web   = ($urandom_range(0, 1) != 0) ? NB'($urandom_range(0, 15)) : '0;
    addra = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
    addrb = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
    dina  = W'($urandom);
    dinb  = W'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    #3 rst = 1'b0;

    // Sweep: ready after exactly D edges
    for (int i = 0; i < 15; i++) step();
    chk("ready_c15", W'(rdy[0]), '0);
    step();
    chk("ready_c16", W'(rdy[0]), 32'd1);

    // Whole array reads zero on both ports
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, '0, AW'(a), '0, 1'b1, '0, AW'(15 - a), '0);
      chk("sweep_zero_a", dout_a[0], '0);
      chk("sweep_zero_va", W'(va[0]), 32'd1);
    end
    idle();

    // Byte-enable merge
    drive(1'b1, 4'b1111, 4'd3, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    drive(1'b1, 4'b0001, 4'd3, 32'h000000AA, 1'b0, '0, '0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, '0, 4'd3, '0);
    chk("be_merge_u0", dout_b[0], 32'hDEADBEAA);
    idle();
    chk("be_merge_oreg_u1", dout_b[1], 32'hDEADBEAA);
    chk("be_merge_oreg_vb_u1", W'(vb[1]), 32'd1);

    // Write/write collision on addr 5
    drive(1'b1, 4'b0011, 4'd5, 32'h11111111, 1'b1, 4'b0110, 4'd5, 32'h22222222);
    chk("ww_coll_u0", W'(co[0]), 32'd1);
    chk("ww_coll_nochange_u2", W'(co[2]), 32'd1);
    drive(1'b1, '0, 4'd5, '0, 1'b0, '0, '0, '0);
    chk("ww_coll_once_u0", W'(co[0]), '0);
    chk("ww_result_u0", dout_a[0], 32'h00221111);

    // Read-during-write modes at addr 7
    drive(1'b1, 4'b1111, 4'd7, 32'h5, 1'b0, '0, '0, '0);
    drive(1'b1, 4'b1111, 4'd7, 32'h9, 1'b0, '0, '0, '0);
    chk("mode0_dout", dout_a[0], 32'h9);
    chk("mode0_valid", W'(va[0]), 32'd1);
    chk("mode2_valid", W'(va[2]), '0);
    chk("mode2_hold", dout_a[2], 32'h00221111);
    idle();
    chk("mode1_dout", dout_a[1], 32'h5);
    chk("mode1_valid", W'(va[1]), 32'd1);

    // Write/read collision at addr 2
    drive(1'b1, 4'b1111, 4'd2, 32'h7, 1'b0, '0, '0, '0);
    drive(1'b1, 4'b1111, 4'd2, 32'h3, 1'b1, '0, 4'd2, '0);
    chk("wr_coll_old", dout_b[0], 32'h7);
    chk("wr_coll_flag", W'(co[0]), 32'd1);
    drive(1'b0, '0, '0, '0, 1'b1, '0, 4'd2, '0);
    chk("wr_coll_after", dout_b[0], 32'h3);
    idle();

    // Reset in the middle of a sweep, with port traffic during CLEAR
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rand_inputs();
      step();
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_outputs("mid_sweep");
    @(posedge clk);
    #4 rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rand_inputs();
      ena = 1'b1;
      step();
      chk("clear_no_valid", W'(va[0]), '0);
    end
    chk("ready_after_restart", W'(rdy[0]), 32'd1);
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, '0, AW'(a), '0, 1'b1, '0, AW'(a), '0);
      chk("restart_zero", dout_a[0], '0);
    end
    idle();

    // Randomized full-rate traffic with frequent collisions
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_tp_be_clr.md
Name: sram_tp_be_clr

Overview:
- Single-clock true dual-port RAM, next generation of the team's dual-port SRAM.
- Adds per-byte write enables, a selectable read-during-write mode per port, and an optional output register stage.
- Adds deterministic same-address collision resolution with a flag, and a hardware clear sweep after reset.
- Sits under packet buffers and descriptor tables that need a known-zero memory without an init file.

Parameters:
- g_D, 512, depth in words; address width AW = clogb2(g_D-1).
- g_W, 32, data width in bits; must be a multiple of g_BW.
- g_BW, 8, byte-lane width; NB = g_W/g_BW lanes.
- g_MODE, 0, read-during-write on the port's own write: 0 write-first, 1 read-first, 2 no-change.
- g_OREG, 0, 1 adds one output register stage (read latency 2 instead of 1).
- g_CLR, 1, 1 enables the post-reset clear sweep; 0 means memory contents are undefined after power-up.

Ports:
- clk  in  1  single clock for both ports
- rst  in  1  asynchronous, active-high reset
- ready  out  1  high when ports accept accesses
- ena  in  1  port A access enable
- wea  in  NB  port A byte write enables; 0 = read
- addra  in  AW  port A address
- dina  in  g_W  port A write data
- douta  out  g_W  port A read data
- valida  out  1  douta qualifier, one-cycle pulse
- enb, web, addrb, dinb, doutb, validb  same as port A, for port B
- coll  out  1  pulse: same-address collision, aligned with data/valid

Behaviour:
- Reset values (asynchronous): douta = doutb = 0, valida = validb = 0, coll = 0, ready = 0 if g_CLR = 1, else 1. Internal pipeline registers also clear. Memory array is not reset.
- FSM (g_CLR = 1), states CLEAR and RUN:
  - rst forces CLEAR with sweep address 0.
  - In CLEAR, write 0 to the sweep address each cycle, then increment.
  - After writing address g_D-1, move to RUN next cycle; ready rises that cycle, exactly g_D cycles after rst deasserts.
  - rst during CLEAR or RUN restarts the sweep at 0.
- FSM with g_CLR = 0: permanently RUN.
- Access gating: in CLEAR, ena/enb/wea/web are ignored; no valid, no coll, no writes from ports.
- Write: for each lane i with wea[i] = 1, mem[addra] lane i <= dina lane i. Other lanes keep their contents. Port B likewise.
- Read latency: an access at edge N gives data/valid at edge N+1 (g_OREG = 0) or N+2 (g_OREG = 1). Output holds its last value between valid pulses.
- valid generation:
  - asserted for every enabled read;
  - asserted for writes in modes 0 and 1;
  - not asserted for writes in mode 2, where dout also holds unchanged.
- Own-port write data returned:
  - mode 0 returns the merged word: old data with written lanes replaced.
  - mode 1 returns the old word.
- Collision: ena & enb & (addra == addrb) & (|wea or |web).
  - coll pulses with the same latency as valid, even if neither port produces valid.
  - Both write: port A wins on lanes enabled on both ports. Lanes enabled on only one port take that port's data.
  - Write on one port, read on the other: the reader returns the pre-write word regardless of g_MODE.
  - The writing port's return data is still governed by g_MODE; in mode 0 it reflects the final stored word (after port A priority).
  - Both read at the same address: no collision and no coll pulse; both return the same word.
- Back-to-back accesses at full rate on both ports: every access is processed, no stalls, no bubbles.

Test Plan:
- g_D = 16, g_CLR = 1: deassert rst, ready rises at cycle 16. Read all 16 addresses on A and B -> all 0, valid 1 cycle after each access.
- Port A: write 0xDEADBEEF to addr 3, wea = 4'b1111. Then port A writes 0x000000AA with wea = 4'b0001. Then port B reads addr 3 -> 0xDEADBEAA. With g_OREG = 1, validb arrives 2 cycles after the read.
- Same addr 5, same cycle:
  - A writes 0x11111111 with wea = 4'b0011; B writes 0x22222222 with web = 4'b0110.
  - Next read of addr 5 -> 0x00221111.
  - coll pulses once.
- Mode 0 / 1 / 2, addr 7 holds 0x5: port A writes 0x9 ->
  - mode 0: douta = 0x9, valida = 1.
  - mode 1: douta = 0x5, valida = 1.
  - mode 2: douta unchanged, valida = 0.
- Same cycle, addr 2 holds 0x7: port A writes 0x3, port B reads addr 2 -> doutb = 0x7, coll = 1. A subsequent read returns 0x3.
- Assert rst at sweep address 9 of 16: all outputs go 0 immediately, ready = 0. After release, ready rises at cycle 16 and the array reads all zeros. Port accesses issued during CLEAR produce no valid and no write.
